// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, data-memory wait freezes,
// taken-branch flushes and an end-of-run drain, with a saturating stall counter.
module pipeline_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        idex_memread_i,
   input  logic [4:0]  idex_rdaddr_i,
   input  logic [4:0]  ifid_rs1addr_i,
   input  logic [4:0]  ifid_rs2addr_i,
   input  logic        branch_taken_i,
   input  logic        exmem_memaccess_i,
   input  logic        dmem_ack_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_write_o,
   output logic        idex_bubble_o,
   output logic        exmem_write_o,
   output logic        memwb_write_o,
   output logic        dmem_req_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt_o
);

   localparam int unsigned CNT_W   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned STALL_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      MEMWAIT = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   drain_cnt, drain_cnt_nxt;
   logic [STALL_W-1:0] stall_cnt;
   logic               stall_c;
   logic               memwait_c;
   logic               loaduse_c;

   // Hazard detection terms
   assign memwait_c = exmem_memaccess_i & ~dmem_ack_i;
   assign loaduse_c = idex_memread_i & (idex_rdaddr_i != 5'd0) &
                      ((idex_rdaddr_i == ifid_rs1addr_i) | (idex_rdaddr_i == ifid_rs2addr_i));

   assign state_o     = state;
   assign stall_cnt_o = stall_cnt;

   // State, drain counter and saturating stall counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         drain_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (stall_c && (stall_cnt != {STALL_W{1'b1}}))
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

   // Next-state and pipeline enable decode
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      stall_c       = 1'b0;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_write_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_write_o = 1'b0;
      memwb_write_o = 1'b0;
      dmem_req_o    = 1'b0;

      unique case (state)
         IDLE: begin
            if (start_i)
               state_nxt = RUN;
         end

         RUN: begin
            if (memwait_c) begin
               // Full freeze while the data memory is busy
               dmem_req_o = 1'b1;
               stall_c    = 1'b1;
               state_nxt  = MEMWAIT;
            end else begin
               pc_write_o    = 1'b1;
               ifid_write_o  = 1'b1;
               idex_write_o  = 1'b1;
               exmem_write_o = 1'b1;
               memwb_write_o = 1'b1;
               if (loaduse_c) begin
                  // Hold PC and IF/ID one cycle, inject a bubble; a branch re-evaluates next cycle
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_bubble_o = 1'b1;
                  stall_c       = 1'b1;
               end else if (branch_taken_i) begin
                  ifid_flush_o = 1'b1;
               end
               if (!start_i) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
               end
            end
         end

         MEMWAIT: begin
            dmem_req_o = 1'b1;
            if (!dmem_ack_i) begin
               stall_c = 1'b1;
            end else begin
               pc_write_o    = 1'b1;
               ifid_write_o  = 1'b1;
               idex_write_o  = 1'b1;
               exmem_write_o = 1'b1;
               memwb_write_o = 1'b1;
               if (start_i) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
               end
            end
         end

         DRAIN: begin
            if (memwait_c) begin
               dmem_req_o = 1'b1;
               stall_c    = 1'b1;
               state_nxt  = MEMWAIT;
            end else begin
               // Stop fetching and flush IF/ID while older instructions retire
               ifid_write_o  = 1'b1;
               ifid_flush_o  = 1'b1;
               idex_write_o  = 1'b1;
               exmem_write_o = 1'b1;
               memwb_write_o = 1'b1;
               if (drain_cnt <= CNT_W'(1)) begin
                  state_nxt     = IDLE;
                  drain_cnt_nxt = '0;
               end else begin
                  drain_cnt_nxt = drain_cnt - CNT_W'(1);
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

   // Packed output view: {pc, ifid_w, flush, idex_w, bubble, exmem_w, memwb_w, req}
   localparam logic [7:0] O_ZERO   = 8'h00;
   localparam logic [7:0] O_ALL    = 8'hD6;
   localparam logic [7:0] O_LU     = 8'h1E;
   localparam logic [7:0] O_FRZ    = 8'h01;
   localparam logic [7:0] O_ACK    = 8'hD7;
   localparam logic [7:0] O_BR     = 8'hF6;
   localparam logic [7:0] O_DRAIN  = 8'h76;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        idex_memread_i;
   logic [4:0]  idex_rdaddr_i;
   logic [4:0]  ifid_rs1addr_i;
   logic [4:0]  ifid_rs2addr_i;
   logic        branch_taken_i;
   logic        exmem_memaccess_i;
   logic        dmem_ack_i;
   logic        pc_write_o;
   logic        ifid_write_o;
   logic        ifid_flush_o;
   logic        idex_write_o;
   logic        idex_bubble_o;
   logic        exmem_write_o;
   logic        memwb_write_o;
   logic        dmem_req_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o;
   logic [7:0]  outs;

   int n_checks = 0;
   int n_pass   = 0;

   pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .idex_memread_i    (idex_memread_i),
      .idex_rdaddr_i     (idex_rdaddr_i),
      .ifid_rs1addr_i    (ifid_rs1addr_i),
      .ifid_rs2addr_i    (ifid_rs2addr_i),
      .branch_taken_i    (branch_taken_i),
      .exmem_memaccess_i (exmem_memaccess_i),
      .dmem_ack_i        (dmem_ack_i),
      .pc_write_o        (pc_write_o),
      .ifid_write_o      (ifid_write_o),
      .ifid_flush_o      (ifid_flush_o),
      .idex_write_o      (idex_write_o),
      .idex_bubble_o     (idex_bubble_o),
      .exmem_write_o     (exmem_write_o),
      .memwb_write_o     (memwb_write_o),
      .dmem_req_o        (dmem_req_o),
      .state_o           (state_o),
      .stall_cnt_o       (stall_cnt_o)
   );

   assign outs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                  idex_bubble_o, exmem_write_o, memwb_write_o, dmem_req_o};

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one edge; inputs change 1ns after the edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle, then compare state, outputs and stall count
   task automatic expect_all(input string tag, input logic [1:0] st, input logic [7:0] o,
                             input logic [15:0] sc);
      #1;
      check({tag, ".state"}, 32'(state_o), 32'(st));
      check({tag, ".outs"},  32'(outs), 32'(o));
      check({tag, ".stall"}, 32'(stall_cnt_o), 32'(sc));
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; idex_memread_i = 1'b0; idex_rdaddr_i = '0;
      ifid_rs1addr_i = '0; ifid_rs2addr_i = '0; branch_taken_i = 1'b0;
      exmem_memaccess_i = 1'b0; dmem_ack_i = 1'b0;
      step(); step();
      expect_all("reset", 2'd0, O_ZERO, 16'd0);

      // Start: IDLE stays until the edge with start_i=1
      rst_i = 1'b0; start_i = 1'b1;
      expect_all("idle_start", 2'd0, O_ZERO, 16'd0);
      step();
      expect_all("run", 2'd1, O_ALL, 16'd0);

      // Load-use via rs2
      idex_memread_i = 1'b1; idex_rdaddr_i = 5'd5; ifid_rs1addr_i = 5'd1; ifid_rs2addr_i = 5'd5;
      expect_all("loaduse", 2'd1, O_LU, 16'd0);
      step();
      idex_memread_i = 1'b0;
      expect_all("after_lu", 2'd1, O_ALL, 16'd1);

      // x0 never stalls
      idex_memread_i = 1'b1; idex_rdaddr_i = 5'd0; ifid_rs1addr_i = 5'd0; ifid_rs2addr_i = 5'd0;
      expect_all("x0_nostall", 2'd1, O_ALL, 16'd1);
      step();
      idex_memread_i = 1'b0;
      expect_all("after_x0", 2'd1, O_ALL, 16'd1);

      // Memory wait: 4 busy cycles then ack
      exmem_memaccess_i = 1'b1; dmem_ack_i = 1'b0;
      expect_all("mw0", 2'd1, O_FRZ, 16'd1);
      step(); expect_all("mw1", 2'd2, O_FRZ, 16'd2);
      step(); expect_all("mw2", 2'd2, O_FRZ, 16'd3);
      step(); expect_all("mw3", 2'd2, O_FRZ, 16'd4);
      step();
      dmem_ack_i = 1'b1;
      expect_all("mw_ack", 2'd2, O_ACK, 16'd5);
      step();
      exmem_memaccess_i = 1'b0; dmem_ack_i = 1'b0;
      expect_all("mw_back", 2'd1, O_ALL, 16'd5);

      // Branch with load-use: stall wins, branch flushes next cycle
      idex_memread_i = 1'b1; idex_rdaddr_i = 5'd7; ifid_rs1addr_i = 5'd7; ifid_rs2addr_i = 5'd2;
      branch_taken_i = 1'b1;
      expect_all("br_lu", 2'd1, O_LU, 16'd5);
      step();
      idex_memread_i = 1'b0;
      expect_all("br_next", 2'd1, O_BR, 16'd6);
      step();
      branch_taken_i = 1'b0;

      // Drain: 3 cycles, start_i ignored mid-drain
      start_i = 1'b0;
      expect_all("run_stop", 2'd1, O_ALL, 16'd6);
      step(); expect_all("drain1", 2'd3, O_DRAIN, 16'd6);
      step();
      start_i = 1'b1;
      expect_all("drain2", 2'd3, O_DRAIN, 16'd6);
      step(); expect_all("drain3", 2'd3, O_DRAIN, 16'd6);
      step(); expect_all("drain_idle", 2'd0, O_ZERO, 16'd6);
      step(); expect_all("rerun", 2'd1, O_ALL, 16'd6);

      // Memwait during drain, then reset drops the request
      start_i = 1'b0;
      step(); expect_all("drain_b", 2'd3, O_DRAIN, 16'd6);
      exmem_memaccess_i = 1'b1;
      expect_all("drain_mw", 2'd3, O_FRZ, 16'd6);
      step(); expect_all("drain_mw2", 2'd2, O_FRZ, 16'd7);
      rst_i = 1'b1;
      step(); expect_all("mid_rst", 2'd0, O_ZERO, 16'd0);
      exmem_memaccess_i = 1'b0; rst_i = 1'b0; start_i = 1'b1;

      // Saturation of the stall counter
      step(); expect_all("sat_run", 2'd1, O_ALL, 16'd0);
      exmem_memaccess_i = 1'b1;
      repeat (65535) step();
      expect_all("sat_max", 2'd2, O_FRZ, 16'hFFFF);
      step(); expect_all("sat_hold", 2'd2, O_FRZ, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have exactly one clock and one synchronous, active-high reset. The reset is sampled only on posedge clk_i.
REQ-002 SHALL expose ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  run request; high = run, low = drain then idle
- idex_memread_i  in  1  instruction in EX is a load
- idex_rdaddr_i  in  5  rd of instruction in EX
- ifid_rs1addr_i  in  5  rs1 of instruction in ID
- ifid_rs2addr_i  in  5  rs2 of instruction in ID
- branch_taken_i  in  1  branch resolved taken in ID
- exmem_memaccess_i  in  1  MEM-stage instruction reads or writes data memory
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_write_o  out  1  ID/EX load enable
- idex_bubble_o  out  1  ID/EX loads zeroed controls
- exmem_write_o  out  1  EX/MEM load enable
- memwb_write_o  out  1  MEM/WB load enable
- dmem_req_o  out  1  outstanding data-memory request
- state_o  out  2  current FSM state
- stall_cnt_o  out  16  total stall cycles
REQ-003 SHALL define parameter DRAIN_CYCLES, default 3: number of cycles spent flushing the pipe after start_i falls.

Function
REQ-004 SHALL implement FSM states IDLE=0, RUN=1, MEMWAIT=2, DRAIN=3, held in state_o.
REQ-005 All *_write_o, flush, bubble and dmem_req_o outputs SHALL be combinational decodes of the registered state and the current inputs.
REQ-006 IDLE SHALL drive all enables, flush, bubble and dmem_req_o to 0. On start_i=1 it SHALL go to RUN at the next edge.
REQ-007 memwait SHALL be defined as exmem_memaccess_i & ~dmem_ack_i.
REQ-008 loaduse SHALL be defined as idex_memread_i & (idex_rdaddr_i!=0) & (idex_rdaddr_i==ifid_rs1addr_i | idex_rdaddr_i==ifid_rs2addr_i).
REQ-009 RUN, with no event, SHALL drive all five enables to 1 and flush, bubble and dmem_req_o to 0.
REQ-010 RUN with memwait SHALL drive all enables to 0 (full freeze) and dmem_req_o to 1, and go to MEMWAIT. This condition has highest priority.
REQ-011 RUN with loaduse and no memwait SHALL drive pc_write_o=0, ifid_write_o=0 and idex_bubble_o=1; all other enables SHALL be 1. State stays RUN and the stall lasts exactly one cycle per hazard occurrence.
REQ-012 RUN with branch_taken_i and neither memwait nor loaduse SHALL drive ifid_flush_o=1 with all enables 1.
REQ-013 When branch_taken_i coincides with loaduse, loaduse SHALL win and ifid_flush_o SHALL be 0. The branch re-evaluates on the next cycle.
REQ-014 RUN with start_i=0 and no memwait SHALL go to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-015 MEMWAIT SHALL hold all enables at 0 and dmem_req_o at 1 while dmem_ack_i=0.
REQ-016 In the MEMWAIT cycle with dmem_ack_i=1, all enables SHALL be 1 and dmem_req_o SHALL be 1. The next state SHALL be RUN if start_i=1, else DRAIN (counter reloaded).
REQ-017 DRAIN SHALL drive pc_write_o=0 and ifid_flush_o=1; all other enables SHALL be 1 and bubble 0.
REQ-018 In DRAIN, the counter SHALL decrement each cycle, and the block SHALL go to IDLE on the edge where the counter is 1.
REQ-019 memwait in DRAIN SHALL behave as in REQ-010 and go to MEMWAIT.
REQ-020 start_i in DRAIN SHALL be ignored.
REQ-021 stall_cnt_o SHALL increment by 1 for each cycle in which a loaduse stall or memwait freeze is driven, including freeze cycles in MEMWAIT. It SHALL saturate at 16'hFFFF with no wrap.
REQ-022 A zero-register rd (x0) SHALL never cause a load-use stall.

Reset
REQ-023 rst_i=1 at a posedge SHALL force state IDLE, drain counter 0 and stall_cnt_o 0. Consequently all enables, flush, bubble and dmem_req_o are 0 from that edge.
REQ-024 rst_i SHALL override start_i and any in-progress MEMWAIT or DRAIN, and the outstanding request SHALL be dropped.
REQ-025 The first transition out of IDLE SHALL occur no earlier than the first edge with rst_i=0 and start_i=1.

Verification
REQ-026 Reset then start_i=1 -> state_o 0 then 1 one edge later; all enables=1, stall_cnt_o=0.
REQ-027 RUN, idex_memread_i=1, idex_rdaddr_i=5, ifid_rs2addr_i=5 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, then stall_cnt_o=1. Repeat with rdaddr=0 -> no stall.
REQ-028 RUN, exmem_memaccess_i=1, dmem_ack_i=0 for 4 cycles then 1 -> 4 cycles of enables=0 (state 2 for 3 of them), full advance on the ack cycle, back to RUN, stall_cnt_o=4.
REQ-029 branch_taken_i=1 together with loaduse -> ifid_flush_o=0 and bubble=1. On the next cycle, with hazard clear, ifid_flush_o=1.
REQ-030 start_i falls in RUN -> state 3 for exactly 3 cycles with pc_write_o=0 and ifid_flush_o=1, then state 0. Assert rst_i mid-DRAIN -> IDLE at the next edge and stall_cnt_o=0.
REQ-031 Force stall_cnt_o to 16'hFFFF via 65535 stalls, then stall again -> stall_cnt_o stays 16'hFFFF.
